// File: rtl/switch_ctrl_rr.sv
// ---------------------------------------------------------------------------
// switch_ctrl_rr -- control unit for a mesh XY switch.
//
// Per input port: a holding-register valid flag with read-while-drain, so each
// input can move one flit per cycle. Per output port: a round-robin arbiter
// with wormhole locking, so every output can transfer concurrently.
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rst_i       synchronous active-high reset
//   empty_i     input FIFO empty flags
//   rd_en_o     input FIFO read strobes (holding register loads on same edge)
//   vld_o       holding register i holds a valid flit
//   dest_i      destination output per input, slice i = [i*SEL_W +: SEL_W]
//   tail_i      held flit is the last flit of its packet
//   full_i      output FIFO full flags
//   wr_en_o     output FIFO write strobes
//   sel_o       crossbar select per output (input index), 0 when not writing
//   lock_o      output is locked to a packet in progress
//   drop_o      one-cycle pulse: held flit discarded (dest >= PORT_N)
//
// Optional feature, macro SWITCH_CTRL_PERF_CNT_EN:
//   cnt_clr_i   synchronous clear of all per-output counters
//   perf_cnt_o  per-output saturating count of wr_en_o pulses (CNT_W each)
// ---------------------------------------------------------------------------
module switch_ctrl_rr #(
    parameter int PORT_N = 5,
    parameter int SEL_W  = $clog2(PORT_N),
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PORT_N-1:0]       empty_i,
    output logic [PORT_N-1:0]       rd_en_o,
    output logic [PORT_N-1:0]       vld_o,
    input  logic [PORT_N*SEL_W-1:0] dest_i,
    input  logic [PORT_N-1:0]       tail_i,
    input  logic [PORT_N-1:0]       full_i,
    output logic [PORT_N-1:0]       wr_en_o,
    output logic [PORT_N*SEL_W-1:0] sel_o,
    output logic [PORT_N-1:0]       lock_o,
    output logic [PORT_N-1:0]       drop_o
`ifdef SWITCH_CTRL_PERF_CNT_EN
    ,
    input  logic                    cnt_clr_i,
    output logic [PORT_N*CNT_W-1:0] perf_cnt_o
`endif
);

    if (PORT_N < 2 || CNT_W < 1) begin : g_param_check
        $error("switch_ctrl_rr: PORT_N must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    logic [PORT_N-1:0]        vld_q;
    logic [PORT_N-1:0]        vld_d;
    logic [PORT_N-1:0]        fire_in;
    logic [SEL_W-1:0]         dest_arr [PORT_N];
    // grant_flat[o*PORT_N + i]: output o writes input i's flit this cycle
    logic [PORT_N*PORT_N-1:0] grant_flat;

    genvar gi;

    for (gi = 0; gi < PORT_N; gi++) begin : g_dest
        assign dest_arr[gi] = dest_i[gi*SEL_W +: SEL_W];
    end

    // ------------------------------------------------------------------
    // Input side: a flit leaves the holding register when granted or
    // dropped; the register refills on the same edge if the FIFO has data.
    // ------------------------------------------------------------------
    always_comb begin
        fire_in = '0;
        drop_o  = '0;
        rd_en_o = '0;
        vld_d   = '0;
        for (int i = 0; i < PORT_N; i++) begin
            drop_o[i]  = vld_q[i] && ({1'b0, dest_arr[i]} >= (SEL_W+1)'(PORT_N));
            fire_in[i] = drop_o[i];
            for (int o = 0; o < PORT_N; o++) begin
                fire_in[i] = fire_in[i] | grant_flat[o*PORT_N + i];
            end
            rd_en_o[i] = ~empty_i[i] & (~vld_q[i] | fire_in[i]);
            vld_d[i]   = rd_en_o[i] | (vld_q[i] & ~fire_in[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign vld_o = vld_q;

    // ------------------------------------------------------------------
    // Output side: one arbiter/FSM per output port.
    // ------------------------------------------------------------------
    for (gi = 0; gi < PORT_N; gi++) begin : g_out
        state_t            state_q, state_d;
        logic [SEL_W-1:0]  owner_q, owner_d;
        logic [SEL_W-1:0]  ptr_q, ptr_d;
        logic [PORT_N-1:0] req;
        logic [PORT_N-1:0] grant;
        logic              found;
        logic [SEL_W-1:0]  winner;
        logic              wr;
        logic [SEL_W-1:0]  sel;
        int                idx;

        always_comb begin
            for (int i = 0; i < PORT_N; i++) begin
                req[i] = vld_q[i] && (dest_arr[i] == SEL_W'(gi));
            end
        end

        // Round-robin scan starting just after the last winner.
        always_comb begin
            found  = 1'b0;
            winner = '0;
            idx    = 0;
            for (int k = 1; k <= PORT_N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= PORT_N) begin
                    idx = idx - PORT_N;
                end
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = SEL_W'(idx);
                end
            end
        end

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            wr      = 1'b0;
            sel     = '0;
            grant   = '0;
            case (state_q)
                ST_IDLE: begin
                    if (found && !full_i[gi]) begin
                        wr            = 1'b1;
                        sel           = winner;
                        grant[winner] = 1'b1;
                        ptr_d         = winner;
                        // A non-tail head flit reserves the output.
                        if (!tail_i[winner]) begin
                            state_d = ST_LOCKED;
                            owner_d = winner;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (req[owner_q] && !full_i[gi]) begin
                        wr             = 1'b1;
                        sel            = owner_q;
                        grant[owner_q] = 1'b1;
                        if (tail_i[owner_q]) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                owner_q <= '0;
                ptr_q   <= SEL_W'(PORT_N - 1);
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
            end
        end

        assign wr_en_o[gi]                         = wr;
        assign sel_o[gi*SEL_W +: SEL_W]            = sel;
        assign lock_o[gi]                          = (state_q == ST_LOCKED);
        assign grant_flat[gi*PORT_N +: PORT_N]     = grant;
    end

`ifdef SWITCH_CTRL_PERF_CNT_EN
    for (gi = 0; gi < PORT_N; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Clear has priority over a same-cycle increment; count saturates.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr_i) begin
                cnt_d = '0;
            end else if (wr_en_o[gi] && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_cnt_o[gi*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: doc/switch_ctrl_rr.md
Name: switch_ctrl_rr

Overview:
- Next-generation control unit for the simple mesh XY switch.
- Per input port: manages a FIFO-read/holding-register valid flag with read-while-drain, giving one flit per cycle per input.
- Per output port: runs a round-robin arbiter with wormhole locking, so all outputs can transfer concurrently.
- Sits between the input FIFOs, the XY route-compute logic (supplies per-input destination/tail) and the output crossbar muxes/output FIFOs.

Parameters:
- PORT_N, 5, number of switch ports (inputs = outputs); minimum 2.
- SEL_W, $clog2(PORT_N), width of port index; derived, not overridden.
- CNT_W, 16, width of per-output flit counters (optional feature only).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- empty_i  in  PORT_N  input FIFO empty flags.
- rd_en_o  out  PORT_N  input FIFO read strobes; external data reg loads on same edge.
- vld_o  out  PORT_N  holding register i holds a valid flit.
- dest_i  in  PORT_N*SEL_W  destination output of flit in holding reg i (slice i = bits [i*SEL_W +: SEL_W]); sampled only when vld_o[i].
- tail_i  in  PORT_N  flit in holding reg i is last flit of its packet (single-flit packet: tail=1).
- full_i  in  PORT_N  output FIFO full flags.
- wr_en_o  out  PORT_N  output FIFO write strobes.
- sel_o  out  PORT_N*SEL_W  crossbar mux select per output (input index); valid when wr_en_o[o].
- lock_o  out  PORT_N  output o is locked to a packet in progress.
- drop_o  out  PORT_N  1-cycle pulse: flit at input i discarded (dest >= PORT_N).

Behaviour:
- Reset (rst_i=1 at edge): vld_q=0, all outputs IDLE, lock_o=0, rr pointer per output = PORT_N-1 (input 0 first priority). rd_en_o/wr_en_o/drop_o combinational, 0 while vld=0 and all empty. Reset mid-packet discards locks and held flits.
- Input side: fire_in[i] = input i's flit consumed this cycle (written to some output or dropped).
- rd_en_o[i] = ~empty_i[i] & (~vld_q[i] | fire_in[i]).
- Next vld_q[i] = rd_en_o[i] | (vld_q[i] & ~fire_in[i]).
- Latency: FIFO read at edge N -> vld at N+1 -> may write at N+1 (same cycle as grant). Sustained 1 flit/cycle/input.
- Request: req[o][i] = vld_q[i] & (dest_i[i]==o).
- Output FSM, IDLE:
  - Winner = first requester scanning i = ptr+1 .. ptr+PORT_N (mod PORT_N).
  - If a winner exists and ~full_i[o]: wr_en_o[o]=1, sel_o[o]=winner, ptr<=winner.
  - If the winner's tail_i=0 -> LOCKED(owner=winner); otherwise stay IDLE.
- Output FSM, LOCKED(owner):
  - Only owner may write; other requesters stall, vld held.
  - Write when req[o][owner] & ~full_i[o].
  - Write with tail_i[owner]=1 -> IDLE.
  - lock_o[o]=1 in LOCKED.
- Full: full_i[o]=1 -> wr_en_o[o]=0, no state/pointer change; requesting inputs hold vld_q and do not read.
- Invalid dest (dest_i[i] >= PORT_N, possible for non-power-of-2 PORT_N): fire_in[i]=1, drop_o[i]=1, no output written.
- Each input requests exactly one output, so fire_in sources never conflict; distinct outputs fire concurrently.
- Idle outputs drive sel_o slice = 0.

Optional Feature:
- Macro SWITCH_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output perf_cnt_o (PORT_N*CNT_W): per-output count of wr_en_o pulses, saturating at all-ones.
  - Adds input cnt_clr_i (1): synchronous clear of all counters; clear wins over a simultaneous increment.
  - Counters reset to 0.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: all empty, rst_i high 2 cycles -> vld_o=0, wr_en_o=0, lock_o=0, rd_en_o=0. Then empty_i[2]=0 with dest=4, tail=1 -> rd_en_o[2] cycle 0, wr_en_o=5'b10000, sel slice4=2 in cycle 1.
- Round robin: inputs 0,1,3 each hold single-flit packets to output 1, FIFOs refill continuously -> grant order 0,1,3,0,1,3; others stay vld until granted.
- Wormhole: input 0 sends 3-flit packet (tail on 3rd) to output 2 while input 4 requests output 2 -> lock_o[2]=1 for cycles 1-2, sel=0 for 3 writes, then input 4 granted on the next cycle.
- Backpressure: full_i[3]=1 for 4 cycles with input 1 requesting output 3 -> wr_en_o[3]=0, rd_en_o[1]=0, vld_o[1]=1 held; first write the cycle full_i drops.
- Concurrency plus reset: inputs 0->1, 1->2, 2->3, 3->4 every cycle -> 4 wr_en bits per cycle. Assert rst_i mid multi-flit packet -> lock_o and vld_o cleared next cycle.
- With SWITCH_CTRL_PERF_CNT_EN, CNT_W=4: 20 writes to output 0 -> perf_cnt slice0 = 15 (saturated); cnt_clr_i pulse -> 0.
